// File: rtl/ppm_symbol_detector.sv
// Streaming PPM symbol detector: accumulates chips per slot over REPS frames and reports the peak slot.
// Optional PPM_SOFT_METRIC_EN tracks a second-best value and reports peak-minus-second as margin.
module ppm_symbol_detector #(
    parameter int PPM_ORDER = 16,
    parameter int CHIP_BITS = 4,
    parameter int REPS      = 1,
    localparam int SYM_BITS = $clog2(PPM_ORDER),
    localparam int ACC_BITS = CHIP_BITS + $clog2(REPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHIP_BITS-1:0] chip_in,
    input  logic                chip_valid,
    output logic                chip_ready,
    input  logic                frame_sync,
    input  logic [ACC_BITS-1:0] corr_threshold,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SYM_BITS-1:0] symbol,
    output logic [ACC_BITS-1:0] peak_value,
    output logic                threshold_unmet,
    output logic [ACC_BITS-1:0] margin,
    output logic                sync_err
);

    localparam int REP_BITS = (REPS > 1) ? $clog2(REPS) : 1;
    localparam logic [SYM_BITS-1:0] LAST_SLOT = SYM_BITS'(PPM_ORDER - 1);
    localparam logic [REP_BITS-1:0] LAST_REP  = REP_BITS'(REPS - 1);

    logic [SYM_BITS-1:0] slot_q, eff_slot, idx_q, idx_nxt;
    logic [REP_BITS-1:0] rep_q, eff_rep;
    logic [ACC_BITS-1:0] acc_q [PPM_ORDER];
    logic [ACC_BITS-1:0] base, cand, max_q, max_nxt;
    logic                accept, last_rep, last_chip;

    assign chip_ready = !(out_valid && !out_ready);
    assign accept     = chip_valid && chip_ready;

    // frame_sync realigns the accepted chip itself, so it is decoded as slot 0 of rep 0
    assign eff_slot  = frame_sync ? '0 : slot_q;
    assign eff_rep   = frame_sync ? '0 : rep_q;
    assign last_rep  = (eff_rep == LAST_REP);
    assign last_chip = accept && last_rep && (eff_slot == LAST_SLOT);

    assign base = (eff_rep == '0) ? '0 : acc_q[eff_slot];
    assign cand = base + ACC_BITS'(chip_in);

`ifdef PPM_SOFT_METRIC_EN
    logic [ACC_BITS-1:0] sec_q, sec_nxt;

    always_comb begin
        max_nxt = max_q;
        idx_nxt = idx_q;
        sec_nxt = sec_q;
        if (accept && last_rep) begin
            if (eff_slot == '0) begin
                max_nxt = cand;
                idx_nxt = '0;
                sec_nxt = '0;
            end else if (cand > max_q) begin
                sec_nxt = max_q;
                max_nxt = cand;
                idx_nxt = eff_slot;
            end else if (cand > sec_q) begin
                sec_nxt = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q  <= '0;
            margin <= '0;
        end else begin
            sec_q <= sec_nxt;
            if (last_chip)
                margin <= max_nxt - sec_nxt;
        end
    end
`else
    always_comb begin
        max_nxt = max_q;
        idx_nxt = idx_q;
        if (accept && last_rep) begin
            if (eff_slot == '0) begin
                max_nxt = cand;
                idx_nxt = '0;
            end else if (cand > max_q) begin
                max_nxt = cand;
                idx_nxt = eff_slot;
            end
        end
    end

    assign margin = '0;
`endif

    // Accumulators carry no reset: rep 0 always overwrites before any read
    always_ff @(posedge clk) begin
        if (accept)
            acc_q[eff_slot] <= cand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q          <= '0;
            rep_q           <= '0;
            max_q           <= '0;
            idx_q           <= '0;
            sync_err        <= 1'b0;
            out_valid       <= 1'b0;
            symbol          <= '0;
            peak_value      <= '0;
            threshold_unmet <= 1'b0;
        end else begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
            if (accept) begin
                if (frame_sync && (slot_q != '0 || rep_q != '0))
                    sync_err <= 1'b1;
                if (eff_slot == LAST_SLOT) begin
                    slot_q <= '0;
                    rep_q  <= last_rep ? '0 : eff_rep + REP_BITS'(1);
                end else begin
                    slot_q <= eff_slot + SYM_BITS'(1);
                    rep_q  <= eff_rep;
                end
            end
            if (last_chip) begin
                out_valid       <= 1'b1;
                symbol          <= idx_nxt;
                peak_value      <= max_nxt;
                threshold_unmet <= (max_nxt < corr_threshold);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ppm_symbol_detector.md
# ppm_symbol_detector

Streaming, parametrised PPM symbol detector for the SPAD receive path: accepts one chip per cycle from the chip sampler, accumulates each slot over `REPS` repeated frames, and finds the slot with the largest accumulated count with a running compare. The registered result is the symbol index, peak value and threshold flag, presented behind a valid/ready handshake to the downstream deframer. It replaces the single-cycle 16-slot combinational correlator wherever chips arrive serially or symbols are repeated.

## Interface
- `PPM_ORDER`, 16: slots per symbol; power of two, ≥2.
- `CHIP_BITS`, 4: width of one chip sample (unsigned).
- `REPS`, 1: frames accumulated per symbol; ≥1.
- Derived `SYM_BITS` = clog2(PPM_ORDER); `ACC_BITS` = CHIP_BITS + clog2(REPS).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `chip_in`  in  CHIP_BITS  chip sample, unsigned.
- `chip_valid`  in  1  `chip_in` valid this cycle.
- `chip_ready`  out  1  detector can accept a chip.
- `frame_sync`  in  1  qualifies the accepted chip as slot 0, rep 0.
- `corr_threshold`  in  ACC_BITS  minimum peak for a valid detection.
- `out_valid`  out  1  result registers hold an unconsumed symbol.
- `out_ready`  in  1  downstream accepts result.
- `symbol`  out  SYM_BITS  index of largest accumulated slot.
- `peak_value`  out  ACC_BITS  accumulated value of that slot.
- `threshold_unmet`  out  1  `peak_value < corr_threshold`.
- `margin`  out  ACC_BITS  peak minus second-best (see Configuration).
- `sync_err`  out  1  sticky: `frame_sync` arrived mid-symbol.

## Operation
- Chip accepted when `chip_valid && chip_ready`. `chip_ready = !(out_valid && !out_ready)` (combinational).
- Counters: `slot` (0..PPM_ORDER-1), `rep` (0..REPS-1). Each accepted chip advances `slot`; wrap of `slot` advances `rep`; wrap of both completes the symbol.
- `frame_sync` on an accepted chip forces that chip to slot 0, rep 0. If counters were not already at slot 0, rep 0, the partial symbol is discarded and `sync_err` sets (cleared only by reset). Before the first `frame_sync` after reset, chips are counted from slot 0 anyway.
- Accumulator array, PPM_ORDER × ACC_BITS: rep 0 writes `chip_in` zero-extended; later reps add `chip_in`. Width covers the worst case; no saturation or overflow possible.
- Last rep: candidate = acc[slot] + chip_in (just chip_in when REPS=1). Running max updated only if candidate > current max (strict). Ties keep the lower index. Slot 0 of the last rep loads the max unconditionally.
- Symbol completion: the cycle after the last chip is accepted, `symbol`, `peak_value`, `threshold_unmet` and `margin` load from the running state and `out_valid` sets. Threshold compare is unsigned and uses `corr_threshold` sampled on the completing chip's cycle.
- `out_valid` clears on `out_valid && out_ready` unless a new result loads in the same cycle, in which case it stays high with the new data. Result outputs are stable while `out_valid && !out_ready`.
- All-zero input gives symbol 0, peak 0, and `threshold_unmet=1` iff threshold > 0.

## Timing
- Reset (async assert, sync deassert expected): `out_valid`, `symbol`, `peak_value`, `threshold_unmet`, `margin`, `sync_err` = 0. Counters and running max cleared. Accumulators need no reset: rep 0 overwrites them. `chip_ready`=1.
- Latency: last chip accepted in cycle N → `out_valid` high in N+1.
- Throughput: one chip/cycle sustained when `out_ready`=1. Back-to-back symbols are supported: first chip of the next symbol may be accepted in cycle N+1.
- Stall: a held result blocks every chip, not just the final one, so no result is ever dropped.
- Reset mid-symbol: partial state discarded, no output produced.

## Configuration
- `PPM_SOFT_METRIC_EN` defined: a second-best register is tracked on the last rep.
  - candidate > max: second ← max, max ← candidate.
  - else if candidate > second: second ← candidate.
  - `margin` = peak − second, registered with the result. Equal values give `margin`=0.
- Undefined: no second-best logic; `margin` tied to 0.

## Test plan
- PPM_ORDER=16, CHIP_BITS=4, REPS=1: chips all 0 except slot 5 = 9, threshold 4 → symbol 5, peak 9, unmet 0, one cycle after slot 15; margin 9 with macro.
- Tie: slots 3 and 11 = 7, rest 2 → symbol 3, peak 7, margin 0.
- REPS=4, ACC_BITS=6: slot 10 = 15 every rep → peak 60, no overflow. Threshold 61 → unmet 1.
- Backpressure: `out_ready`=0 across completion plus next 5 chips → `chip_ready`=0 from N+1, outputs stable. Release → accept, next symbol resumes.
- `frame_sync` at slot 7 → `sync_err`=1, partial discarded, next full symbol decoded correctly.
- Assert `rst_n` at slot 9 → all outputs 0 immediately, no result emitted; a clean symbol after deassert is correct.
